ddr_test_ctrl: RTL and testbench

DDR_TEST_CTRL -- requirements
Module: ddr_test_ctrl

---
 rtl/ddr_test_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_ddr_test_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_test_ctrl.sv
// DDR write-then-readback pattern tester: writes test_len bursts of a word-indexed
// pattern, reads them back, counts mismatches and reports through a read-only Sir slave.
module ddr_test_ctrl #(
    parameter int          SLAVE_SIZE = 16,
    parameter int          BURST_LEN  = 16,
    parameter logic [15:0] STAT_ADDR  = 16'h3010,
    parameter logic [15:0] ERR_ADDR   = 16'h3014
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ddr_test_start,
    input  logic [31:0]           test_len,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic                  cmd_wr,
    output logic [31:0]           cmd_addr,
    output logic                  wdat_valid,
    input  logic                  wdat_ready,
    output logic [31:0]           wdat,
    input  logic                  rdat_valid,
    input  logic [31:0]           rdat,
    input  logic [SLAVE_SIZE-1:0] SirAddr,
    input  logic                  SirRead,
    input  logic                  SirSel,
    output logic                  SirDack,
    output logic [31:0]           SirRdat
);
    localparam int                    BEAT_W      = $clog2(BURST_LEN + 1);
    localparam logic [31:0]           PAT_KEY     = 32'hA5A5_5A5A;
    localparam logic [31:0]           BURST_WORDS = 32'(BURST_LEN);
    localparam logic [BEAT_W-1:0]     LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
    localparam logic [BEAT_W-1:0]     BEAT_ONE    = BEAT_W'(1);
    localparam logic [SLAVE_SIZE-1:0] STAT_SEL    = SLAVE_SIZE'(STAT_ADDR);
    localparam logic [SLAVE_SIZE-1:0] ERR_SEL     = SLAVE_SIZE'(ERR_ADDR);

    typedef enum logic [2:0] {IDLE, WR_CMD, WR_DATA, RD_CMD, RD_DATA, DONE} state_t;

    state_t            state_q, state_d;
    logic [31:0]       len_q, len_d;
    logic [31:0]       burst_q, burst_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [31:0]       err_q, err_d;
    logic              start_q;
    logic              sir_dack_q, sir_dack_d;
    logic [31:0]       sir_rdat_q, sir_rdat_d;

    logic [31:0] word;
    logic        last_beat, last_burst, launch;
    logic        busy, done, pass;
    logic [31:0] status;

    function automatic logic [31:0] pattern(input logic [31:0] w);
        return w ^ PAT_KEY;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign word       = burst_q * BURST_WORDS + 32'(beat_q);
    assign last_beat  = (beat_q == LAST_BEAT);
    assign last_burst = (burst_q == len_q - 32'd1);
    assign launch     = ddr_test_start && !start_q && (state_q == IDLE || state_q == DONE);

    assign busy   = (state_q != IDLE) && (state_q != DONE);
    assign done   = (state_q == DONE);
    assign pass   = done && (err_q == 32'd0);
    assign status = {29'd0, pass, done, busy};

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        burst_d    = burst_q;
        beat_d     = beat_q;
        err_d      = err_q;
        cmd_valid  = 1'b0;
        cmd_wr     = 1'b0;
        cmd_addr   = '0;
        wdat_valid = 1'b0;
        wdat       = '0;
        case (state_q)
            WR_CMD: begin
                cmd_valid = 1'b1;
                cmd_wr    = 1'b1;
                cmd_addr  = {word[29:0], 2'b00};
                if (cmd_ready) state_d = WR_DATA;
            end
            WR_DATA: begin
                wdat_valid = 1'b1;
                wdat       = pattern(word);
                if (wdat_ready) begin
                    if (last_beat) begin
                        beat_d = '0;
                        if (last_burst) begin
                            burst_d = '0;
                            state_d = RD_CMD;
                        end else begin
                            burst_d = burst_q + 32'd1;
                            state_d = WR_CMD;
                        end
                    end else begin
                        beat_d = beat_q + BEAT_ONE;
                    end
                end
            end
            RD_CMD: begin
                cmd_valid = 1'b1;
                cmd_addr  = {word[29:0], 2'b00};
                if (cmd_ready) state_d = RD_DATA;
            end
            RD_DATA: begin
                // Read data only counts while a read burst is open; stray beats elsewhere are dropped.
                if (rdat_valid) begin
                    if (rdat != pattern(word)) err_d = sat_inc(err_q);
                    if (last_beat) begin
                        beat_d = '0;
                        if (last_burst) begin
                            state_d = DONE;
                        end else begin
                            burst_d = burst_q + 32'd1;
                            state_d = RD_CMD;
                        end
                    end else begin
                        beat_d = beat_q + BEAT_ONE;
                    end
                end
            end
            default: ;
        endcase
        if (launch) begin
            len_d   = test_len;
            burst_d = '0;
            beat_d  = '0;
            err_d   = '0;
            state_d = (test_len == 32'd0) ? DONE : WR_CMD;
        end
    end

    always_comb begin
        sir_dack_d = 1'b0;
        sir_rdat_d = '0;
        if (SirSel && SirRead) begin
            if (SirAddr == STAT_SEL) begin
                sir_dack_d = 1'b1;
                sir_rdat_d = status;
            end else if (SirAddr == ERR_SEL) begin
                sir_dack_d = 1'b1;
                sir_rdat_d = err_q;
            end
        end
    end

    // start_q resets high so a start level held through reset is not seen as an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            burst_q    <= '0;
            beat_q     <= '0;
            err_q      <= '0;
            start_q    <= 1'b1;
            sir_dack_q <= 1'b0;
            sir_rdat_q <= '0;
        end else begin
            state_q    <= state_d;
            burst_q    <= burst_d;
            beat_q     <= beat_d;
            err_q      <= err_d;
            start_q    <= ddr_test_start;
            sir_dack_q <= sir_dack_d;
            sir_rdat_q <= sir_rdat_d;
        end
    end

    always_ff @(posedge clk) begin
        len_q <= len_d;
    end

    assign SirDack = sir_dack_q;
    assign SirRdat = sir_rdat_q;
endmodule

// File: tb/tb_ddr_test_ctrl.sv
// Scoreboard bench for ddr_test_ctrl: a memory model answers commands, a negedge monitor
// compares every handshake and Sir response against queues filled from a burst-level model.
module tb_ddr_test_ctrl;
    localparam int          BL     = 16;
    localparam logic [15:0] STAT_A = 16'h3010;
    localparam logic [15:0] ERR_A  = 16'h3014;
    localparam logic [31:0] KEY    = 32'hA5A5_5A5A;

    logic        clk, rst, ddr_test_start;
    logic [31:0] test_len;
    logic        cmd_valid, cmd_ready, cmd_wr;
    logic [31:0] cmd_addr;
    logic        wdat_valid, wdat_ready;
    logic [31:0] wdat;
    logic        rdat_valid;
    logic [31:0] rdat;
    logic [15:0] SirAddr;
    logic        SirRead, SirSel, SirDack;
    logic [31:0] SirRdat;

    ddr_test_ctrl #(.SLAVE_SIZE(16), .BURST_LEN(BL), .STAT_ADDR(STAT_A), .ERR_ADDR(ERR_A)) dut (
        .clk(clk), .rst(rst), .ddr_test_start(ddr_test_start), .test_len(test_len),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr),
        .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat(wdat),
        .rdat_valid(rdat_valid), .rdat(rdat),
        .SirAddr(SirAddr), .SirRead(SirRead), .SirSel(SirSel), .SirDack(SirDack), .SirRdat(SirRdat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [32:0] exp_cmd[$];
    logic [31:0] exp_wdat[$];
    logic [31:0] rd_q[$];
    logic [31:0] exp_sir[$];
    string       sir_name[$];
    string       chk_name[$];
    logic [31:0] chk_act[$];
    logic [31:0] chk_exp[$];
    logic [31:0] mem[int unsigned];

    int checks = 0, errors = 0;
    int cmd_cnt = 0, wdat_cnt = 0, rd_sent = 0;
    int unsigned wr_word = 0;
    int corrupt_idx;
    bit stall_en;
    bit cmd_stall = 0, wdat_stall = 0;
    logic [32:0] cmd_hold;
    logic [31:0] wdat_hold;

    // Monitor, memory model and scoreboard: the only process that counts comparisons.
    always @(negedge clk) begin
        logic [31:0] e, a, w, d;
        logic [32:0] ec;
        string n;
        checks++;
        if (SirDack) begin
            if (exp_sir.size() == 0) begin
                errors++;
                $display("FAIL sir_dack: got unexpected ack with data %h, required no ack", SirRdat);
            end else begin
                e = exp_sir.pop_front();
                n = sir_name.pop_front();
                if (SirRdat !== e) begin
                    errors++;
                    $display("FAIL %s: got %h, required %h", n, SirRdat, e);
                end
            end
        end else if (SirRdat !== 32'd0) begin
            errors++;
            $display("FAIL sir_idle_rdat: got %h, required 0", SirRdat);
        end

        if (rst) begin
            cmd_stall  = 0;
            wdat_stall = 0;
        end else begin
            if (cmd_stall) begin
                checks++;
                if (!cmd_valid || {cmd_wr, cmd_addr} !== cmd_hold) begin
                    errors++;
                    $display("FAIL cmd_stable: got v=%b %h, required v=1 %h", cmd_valid, {cmd_wr, cmd_addr}, cmd_hold);
                end
            end
            if (wdat_stall) begin
                checks++;
                if (!wdat_valid || wdat !== wdat_hold) begin
                    errors++;
                    $display("FAIL wdat_stable: got v=%b %h, required v=1 %h", wdat_valid, wdat, wdat_hold);
                end
            end
        end
        cmd_stall  = 0;
        wdat_stall = 0;

        if (rd_q.size() > 0 && (!stall_en || $urandom_range(3) != 0)) begin
            rdat_valid = 1'b1;
            rdat       = rd_q.pop_front();
            rd_sent++;
        end else begin
            rdat_valid = 1'b0;
            rdat       = $urandom;
        end
        cmd_ready  = stall_en ? ($urandom_range(1) == 1) : 1'b1;
        wdat_ready = stall_en ? ($urandom_range(2) != 0) : 1'b1;

        if (!rst && cmd_valid) begin
            if (cmd_ready) begin
                cmd_cnt++;
                checks++;
                if (exp_cmd.size() == 0) begin
                    errors++;
                    $display("FAIL cmd: got unexpected wr=%b addr=%h, required none", cmd_wr, cmd_addr);
                end else begin
                    ec = exp_cmd.pop_front();
                    if ({cmd_wr, cmd_addr} !== ec) begin
                        errors++;
                        $display("FAIL cmd: got wr=%b addr=%h, required wr=%b addr=%h", cmd_wr, cmd_addr, ec[32], ec[31:0]);
                    end
                end
                if (cmd_wr) begin
                    wr_word = cmd_addr >> 2;
                end else begin
                    for (int k = 0; k < BL; k++) begin
                        w = (cmd_addr >> 2) + 32'(k);
                        d = mem.exists(w) ? mem[w] : 32'hDEAD_BEEF;
                        if (corrupt_idx >= 0 && w == 32'(corrupt_idx)) d = d ^ 32'h1;
                        rd_q.push_back(d);
                    end
                end
            end else begin
                cmd_stall = 1;
                cmd_hold  = {cmd_wr, cmd_addr};
            end
        end
        if (!rst && wdat_valid) begin
            if (wdat_ready) begin
                wdat_cnt++;
                checks++;
                if (exp_wdat.size() == 0) begin
                    errors++;
                    $display("FAIL wdat: got unexpected %h, required none", wdat);
                end else begin
                    e = exp_wdat.pop_front();
                    if (wdat !== e) begin
                        errors++;
                        $display("FAIL wdat: got %h, required %h", wdat, e);
                    end
                end
                mem[wr_word] = wdat;
                wr_word++;
            end else begin
                wdat_stall = 1;
                wdat_hold  = wdat;
            end
        end

        while (chk_name.size() > 0) begin
            n = chk_name.pop_front();
            a = chk_act.pop_front();
            e = chk_exp.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got %h, required %h", n, a, e);
            end
        end
    end

    task automatic push_chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        chk_name.push_back(n);
        chk_act.push_back(act);
        chk_exp.push_back(exp);
    endtask

    task automatic sir_read(input logic [15:0] a, input logic [31:0] e, input string n);
        @(negedge clk);
        SirSel = 1'b1; SirRead = 1'b1; SirAddr = a;
        exp_sir.push_back(e);
        sir_name.push_back(n);
        @(negedge clk);
        SirSel = 1'b0; SirRead = 1'b0; SirAddr = '0;
        repeat (2) @(negedge clk);
        push_chk({n, "_acked"}, 32'(exp_sir.size()), 32'd0);
    endtask

    // Burst-level model of the whole test: every write command, its data, then every read command.
    task automatic launch(input int len);
        for (int b = 0; b < len; b++) begin
            exp_cmd.push_back({1'b1, 32'(b * BL * 4)});
            for (int k = 0; k < BL; k++) exp_wdat.push_back(32'(b * BL + k) ^ KEY);
        end
        for (int b = 0; b < len; b++) exp_cmd.push_back({1'b0, 32'(b * BL * 4)});
        test_len = 32'(len);
        @(negedge clk) ddr_test_start = 1'b0;
        @(negedge clk) ddr_test_start = 1'b1;
    endtask

    task automatic run_test(input int len, input int corrupt, input bit stall, input bit restart_mid);
        int cbase, wbase, rbase, cyc, exp_err;
        stall_en    = stall;
        corrupt_idx = corrupt;
        cbase = cmd_cnt; wbase = wdat_cnt; rbase = rd_sent;
        launch(len);
        @(negedge clk) test_len = $urandom;
        if (restart_mid) begin
            cyc = 0;
            while (wdat_cnt - wbase < 5 && cyc < 5000) begin @(negedge clk); cyc++; end
            ddr_test_start = 1'b0;
            @(negedge clk) ddr_test_start = 1'b1;
        end
        cyc = 0;
        while (rd_sent - rbase < len * BL && cyc < 20000) begin @(negedge clk); cyc++; end
        push_chk("read_beats", 32'(rd_sent - rbase), 32'(len * BL));
        repeat (3) @(negedge clk);
        exp_err = (corrupt >= 0 && corrupt < len * BL) ? 1 : 0;
        sir_read(STAT_A, (exp_err == 0) ? 32'h6 : 32'h2, "status");
        sir_read(ERR_A, 32'(exp_err), "err_count");
        repeat (10) @(negedge clk);
        push_chk("cmd_count", 32'(cmd_cnt - cbase), 32'(2 * len));
        push_chk("wdat_count", 32'(wdat_cnt - wbase), 32'(len * BL));
        push_chk("cmd_left", 32'(exp_cmd.size()), 32'd0);
        push_chk("wdat_left", 32'(exp_wdat.size()), 32'd0);
    endtask

    initial begin
        int cbase, rbase, cyc, len;
        rst = 1'b1; ddr_test_start = 1'b1; test_len = 32'd3;
        SirSel = 1'b0; SirRead = 1'b0; SirAddr = '0;
        stall_en = 0; corrupt_idx = -1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        push_chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        push_chk("rst_wdat_valid", {31'd0, wdat_valid}, 32'd0);
        push_chk("rst_no_launch", 32'(cmd_cnt), 32'd0);
        sir_read(STAT_A, 32'd0, "rst_status");
        sir_read(ERR_A, 32'd0, "rst_err");

        @(negedge clk);
        SirSel = 1'b1; SirRead = 1'b0; SirAddr = STAT_A;
        @(negedge clk);
        SirRead = 1'b1; SirAddr = 16'h3000;
        @(negedge clk);
        SirSel = 1'b0; SirRead = 1'b0; SirAddr = '0;
        repeat (2) @(negedge clk);

        run_test(2, -1, 0, 0);
        run_test(2, 5, 0, 0);

        cbase = cmd_cnt;
        stall_en = 0; corrupt_idx = -1;
        launch(0);
        sir_read(STAT_A, 32'h6, "len0_status");
        sir_read(ERR_A, 32'd0, "len0_err");
        repeat (10) @(negedge clk);
        push_chk("len0_cmds", 32'(cmd_cnt - cbase), 32'd0);

        for (int i = 0; i < 3; i++) begin
            len = $urandom_range(1, 4);
            run_test(len, ($urandom_range(1) == 1) ? int'($urandom_range(0, len * BL - 1)) : -1, 1, 0);
        end

        run_test(3, -1, 1, 1);

        stall_en = 0; corrupt_idx = -1;
        rbase = rd_sent;
        launch(2);
        cyc = 0;
        while (rd_sent - rbase < 3 && cyc < 2000) begin @(negedge clk); cyc++; end
        push_chk("abort_reached_read", {31'd0, rd_sent - rbase >= 3}, 32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_cmd.delete();
        exp_wdat.delete();
        cbase = cmd_cnt;
        repeat (20) @(negedge clk);
        rd_q.delete();
        push_chk("abort_no_cmd", 32'(cmd_cnt - cbase), 32'd0);
        sir_read(STAT_A, 32'd0, "abort_status");
        sir_read(ERR_A, 32'd0, "abort_err");

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
